// File: rtl/iota_stream_rc_pkg.sv
// Shared types and constants for the streaming Keccak iota stage.
// Holds the slice width, the round-constant LFSR definition and the FSM states.
package iota_stream_rc_pkg;

    localparam int unsigned SLICE_W   = 25;
    localparam logic [7:0]  LFSR_INIT = 8'h01;
    // x^8 + x^6 + x^5 + x^4 + 1: feedback from bit 7 into bits 0, 4, 5, 6
    localparam logic [7:0]  LFSR_TAPS = 8'h71;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        STREAM,
        DONE
    } state_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/iota_stream_rc_rc_gen.sv
// Round-constant generator: steps the rc(t) LFSR from t=0 to 7*ir+L and
// scatters rc(7*ir+j) into bit 2^j-1 of a W-bit constant.
module iota_stream_rc_rc_gen
    import iota_stream_rc_pkg::*;
#(
    parameter int unsigned L  = 6,
    parameter int unsigned NR = 24,
    parameter int unsigned RW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [RW-1:0]       ir,
    output logic [(1 << L)-1:0] rc,
    output logic                rc_done_c
);

    localparam int unsigned W   = 1 << L;
    localparam int unsigned T_W = $clog2(7 * NR + L + 1);

    logic [7:0]     lfsr_q, lfsr_d;
    logic [T_W-1:0] t_q, t_d;
    logic [T_W-1:0] base_q, base_d;
    logic [W-1:0]   rc_q, rc_d;
    logic           run_q, run_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= '0;
            t_q    <= '0;
            base_q <= '0;
            rc_q   <= '0;
            run_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            t_q    <= t_d;
            base_q <= base_d;
            rc_q   <= rc_d;
            run_q  <= run_d;
        end
    end

    // One LFSR step per running cycle; sampled bits land only at positions 2^j-1
    always_comb begin
        lfsr_d = lfsr_q;
        t_d    = t_q;
        base_d = base_q;
        rc_d   = rc_q;
        run_d  = run_q;
        if (go) begin
            lfsr_d = LFSR_INIT;
            t_d    = '0;
            base_d = T_W'(ir) * T_W'(7);
            rc_d   = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            for (int unsigned j = 0; j <= L; j++) begin
                if (t_q == base_q + T_W'(j)) begin
                    rc_d = rc_d | (W'(lfsr_q[0]) << ((1 << j) - 1));
                end
            end
            lfsr_d = lfsr_step(lfsr_q);
            t_d    = t_q + T_W'(1);
            if (t_q == base_q + T_W'(L)) begin
                run_d = 1'b0;
            end
        end
    end

    assign rc        = rc_q;
    assign rc_done_c = run_q && (t_q == base_q + T_W'(L));

endmodule

// File: rtl/iota_stream_rc.sv
// Streaming Keccak iota step: XORs the generated round constant into lane (0,0),
// one 25-bit slice per beat, with a single registered output stage.
module iota_stream_rc
    import iota_stream_rc_pkg::*;
#(
    parameter int unsigned L  = 6,
    parameter int unsigned NR = 24,
    parameter int unsigned RW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [RW-1:0]      round_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLICE_W-1:0] in_slice,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_slice,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned W  = 1 << L;
    localparam int unsigned ZW = (L > 0) ? L : 1;

    state_e             state_q, state_d;
    logic [ZW-1:0]      z_q, z_d;
    logic               ov_q, ov_d;
    logic [SLICE_W-1:0] os_q, os_d;
    logic               ol_q, ol_d;
    logic               last_in_q, last_in_d;
    logic               err_q, err_d;
    logic               go_c;
    logic               rc_done_c;
    logic [W-1:0]       rc;
    logic               in_hs_c, out_hs_c, z_last_c;

    iota_stream_rc_rc_gen #(.L(L), .NR(NR), .RW(RW)) u_rc_gen (
        .clk       (clk),
        .rst       (rst),
        .go        (go_c),
        .ir        (round_in),
        .rc        (rc),
        .rc_done_c (rc_done_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            z_q       <= '0;
            ov_q      <= 1'b0;
            os_q      <= '0;
            ol_q      <= 1'b0;
            last_in_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            z_q       <= z_d;
            ov_q      <= ov_d;
            os_q      <= os_d;
            ol_q      <= ol_d;
            last_in_q <= last_in_d;
            err_q     <= err_d;
        end
    end

    // Input is closed once the final slice has been taken, until the round ends
    assign in_ready = (state_q == STREAM) && !last_in_q && (!ov_q || out_ready);
    assign in_hs_c  = in_valid && in_ready;
    assign out_hs_c = ov_q && out_ready;
    assign z_last_c = (z_q == ZW'(W - 1));

    always_comb begin
        state_d   = state_q;
        z_d       = z_q;
        ov_d      = ov_q;
        os_d      = os_q;
        ol_d      = ol_q;
        last_in_d = last_in_q;
        err_d     = 1'b0;
        go_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(round_in) < NR) begin
                        go_c      = 1'b1;
                        z_d       = '0;
                        last_in_d = 1'b0;
                        state_d   = GEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GEN: begin
                if (rc_done_c) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_hs_c) begin
                    ov_d = 1'b0;
                end
                // A same-cycle input beat reloads the register behind the drained one
                if (in_hs_c) begin
                    os_d      = in_slice ^ SLICE_W'(rc[z_q]);
                    ov_d      = 1'b1;
                    ol_d      = z_last_c;
                    last_in_d = last_in_q | z_last_c;
                    z_d       = z_last_c ? '0 : z_q + ZW'(1);
                end
                if (out_hs_c && ol_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ol_d      = 1'b0;
                last_in_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = ov_q;
    assign out_slice = os_q;
    assign out_last  = ol_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_iota_stream_rc.sv
// Directed bench: a 64-bit-lane instance and an 8-bit-lane instance share one stimulus path.
module tb_iota_stream_rc;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        start;
    logic [4:0]  round_in;
    logic        in_valid;
    logic [24:0] in_slice;
    logic        out_ready;

    logic        start_a, in_valid_a, in_ready_a, out_valid_a, out_last_a, busy_a, done_a, err_a;
    logic [24:0] out_slice_a;
    logic        start_b, in_valid_b, in_ready_b, out_valid_b, out_last_b, busy_b, done_b, err_b;
    logic [24:0] out_slice_b;
    logic        in_ready_m, out_valid_m, out_last_m, busy_m, done_m, err_m;
    logic [24:0] out_slice_m;

    int tests = 0;
    int fails = 0;

    logic [7:0] rc8 [18] = '{8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01, 8'h81, 8'h09, 8'h8A,
                             8'h88, 8'h09, 8'h0A, 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80};

    assign start_a    = start & ~sel;
    assign start_b    = start & sel;
    assign in_valid_a = in_valid & ~sel;
    assign in_valid_b = in_valid & sel;

    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign out_slice_m = sel ? out_slice_b : out_slice_a;
    assign out_last_m  = sel ? out_last_b  : out_last_a;
    assign busy_m      = sel ? busy_b      : busy_a;
    assign done_m      = sel ? done_b      : done_a;
    assign err_m       = sel ? err_b       : err_a;

    iota_stream_rc #(.L(6), .NR(24), .RW(5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .round_in(round_in),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_slice(in_slice),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_slice(out_slice_a),
        .out_last(out_last_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    iota_stream_rc #(.L(3), .NR(18), .RW(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .round_in(round_in),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_slice(in_slice),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_slice(out_slice_b),
        .out_last(out_last_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] pat(input int mode, input int i);
        case (mode)
            0:       return 25'h0;
            1:       return 25'h1FFFFFF;
            default: return 25'(32'h9E3779B1 * 32'(i + 1));
        endcase
    endfunction

    // Runs one round on the selected instance; abort>0 stops once that many slices were sent
    task automatic do_round(input int l, input int ir, input logic [63:0] rc, input int mode,
                            input int stall, input bit poke, input int abort);
        logic [24:0] q[$];
        logic [24:0] held_s;
        logic [24:0] e;
        logic        held_l;
        logic        hold;
        int          w, gen_cnt, sent, got, dn, cyc;
        w = 1 << l;
        @(negedge clk);
        start = 1'b1; round_in = 5'(ir); out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        gen_cnt = 0;
        #1;
        while (!in_ready_m && gen_cnt < 400) begin
            gen_cnt++;
            @(negedge clk);
            if (poke && gen_cnt == 3) begin
                start = 1'b1; round_in = 5'd0;
            end else begin
                start = 1'b0;
            end
            #1;
        end
        start = 1'b0;
        check("gen_cycles", 64'(gen_cnt), 64'(7 * ir + l + 1));
        hold = 1'b0; held_s = '0; held_l = 1'b0;
        sent = 0; got = 0; dn = 0; cyc = 0;
        while (dn == 0 && cyc < 2000) begin
            if (abort > 0 && sent == abort) break;
            in_valid  = (sent < w);
            in_slice  = pat(mode, sent);
            out_ready = ($urandom_range(0, 99) >= stall);
            #1;
            if (hold) begin
                check("stall_valid", 64'(out_valid_m), 64'd1);
                check("stall_slice", 64'(out_slice_m), 64'(held_s));
                check("stall_last", 64'(out_last_m), 64'(held_l));
            end
            if (out_valid_m && out_ready) begin
                if (q.size() == 0) begin
                    check("extra_beat", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("slice", 64'(out_slice_m), 64'(e));
                    check("last", 64'(out_last_m), 64'(got == w - 1));
                end
                got++;
                hold = 1'b0;
            end else if (out_valid_m) begin
                hold = 1'b1; held_s = out_slice_m; held_l = out_last_m;
            end else begin
                hold = 1'b0;
            end
            if (done_m) dn++;
            if (in_valid && in_ready_m) begin
                q.push_back(in_slice ^ 25'(rc[sent]));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (abort > 0) return;
        check("done_seen", 64'(dn), 64'd1);
        check("beats_out", 64'(got), 64'(w));
        check("beats_in", 64'(sent), 64'(w));
        check("queue_empty", 64'(q.size()), 64'd0);
        #1;
        check("done_once", 64'(done_m), 64'd0);
        check("idle_after", 64'(busy_m), 64'd0);
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; start = 1'b0; round_in = '0;
        in_valid = 1'b0; in_slice = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy_m), 64'd0);
        check("rst_valid", 64'(out_valid_m), 64'd0);
        check("rst_ready", 64'(in_ready_m), 64'd0);
        check("rst_slice", 64'(out_slice_m), 64'd0);
        check("rst_last", 64'(out_last_m), 64'd0);
        check("rst_done", 64'(done_m), 64'd0);
        check("rst_err", 64'(err_m), 64'd0);
        rst = 1'b1;

        do_round(6, 0,  64'h0000000000000001, 0, 0,  1'b0, 0);
        do_round(6, 1,  64'h0000000000008082, 1, 0,  1'b0, 0);
        do_round(6, 23, 64'h8000000080008008, 2, 0,  1'b0, 0);
        do_round(6, 5,  64'h0000000080000001, 2, 30, 1'b1, 0);

        // Out-of-range round index
        @(negedge clk);
        start = 1'b1; round_in = 5'd24;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("err_pulse", 64'(err_m), 64'd1);
        check("err_busy", 64'(busy_m), 64'd0);
        @(negedge clk);
        #1;
        check("err_clear", 64'(err_m), 64'd0);
        check("err_busy2", 64'(busy_m), 64'd0);

        // Reset after slice z=30 has been accepted
        do_round(6, 2, 64'h800000000000808A, 0, 0, 1'b0, 31);
        rst = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid_m), 64'd0);
        check("abort_slice", 64'(out_slice_m), 64'd0);
        check("abort_busy", 64'(busy_m), 64'd0);
        check("abort_ready", 64'(in_ready_m), 64'd0);
        check("abort_done", 64'(done_m), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_done2", 64'(done_m), 64'd0);
        do_round(6, 1, 64'h0000000000008082, 1, 0, 1'b0, 0);

        sel = 1'b1;
        for (int i = 0; i < 18; i++) begin
            do_round(3, i, {56'h0, rc8[i]}, 2, 0, 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iota_stream_rc.md
Name: iota_stream_rc

Overview:
- Parametrised successor to the file-based add-round-constant datapath.
- Applies the Keccak iota step (XOR of the round constant into lane (0,0)) to a state streamed one 25-bit slice per beat over valid/ready handshakes, replacing file read/write.
- Generates the round constant internally with the rc(t) LFSR instead of a fixed 64-bit table, so any lane width 2^L is supported.
- Sits between the preceding step-mapping stage and the next round stage of the permutation pipeline.

Parameters:
- L, 6, log2 of lane width; lane width W = 2^L (1..64), slices per round = W.
- NR, 24, number of valid rounds (12+2L for standard Keccak-f).
- RW, 5, width of round_in.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to process one round; accepted only in IDLE.
- round_in  in  RW  round index ir, sampled with start.
- in_valid  in  1  in_slice valid.
- in_ready  out  1  block accepts in_slice this cycle.
- in_slice  in  25  slice z; bit 5*y+x = lane(x,y) bit z.
- out_valid  out  1  out_slice valid.
- out_ready  in  1  downstream accepts out_slice.
- out_slice  out  25  processed slice.
- out_last  out  1  high with the slice z=W-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last slice is accepted downstream.
- err  out  1  one-cycle pulse when start is given with round_in >= NR.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; z counter, LFSR, RC register and output register cleared; all outputs 0.
- FSM states: IDLE, GEN, STREAM, DONE.
- IDLE -> GEN: start=1 and round_in<NR. Latch ir, clear RC, LFSR := 8'h01, t := 0.
- IDLE with start=1 and round_in>=NR: pulse err next cycle, stay IDLE.
- GEN: one LFSR step per cycle, t from 0 to 7*ir+L, so GEN lasts 7*ir+L+1 cycles.
  - LFSR taps: x^8+x^6+x^5+x^4+1. rc(t) = R[0] of the state after t steps.
  - When t = 7*ir+j (j=0..L), set RC[2^j-1] := rc(t). All other RC bits stay 0.
  - Exit to STREAM after t = 7*ir+L.
- STREAM:
  - in_ready = !out_valid || out_ready.
  - On an in handshake: out_slice := in_slice with bit 0 XOR RC[z]; out_valid := 1; out_last := (z==W-1); z := z+1 (wraps to 0 after W-1).
  - After the z=W-1 slice is accepted on input, in_ready=0 until the FSM returns to IDLE.
  - Go to DONE when the last slice handshakes on output.
- Latency: 1 cycle in to out; full throughput of 1 slice/cycle under continuous ready.
- Backpressure: out_slice and out_last stay stable while out_valid && !out_ready.
- DONE: done=1 for one cycle, then IDLE.
- Ignored inputs:
  - start outside IDLE.
  - in_valid outside STREAM (in_ready=0 there).
- Simultaneous out handshake and in handshake in the same cycle: the register is reloaded, with no bubble.
- Reset mid-round: the partial round is discarded and no done pulse is produced.
- Only bit 0 of each slice is modified; bits 24:1 pass through unchanged.

Decomposition:
- Shared package:
  - SLICE_W = 25.
  - LFSR_INIT = 8'h01.
  - LFSR tap mask.
  - FSM state enum {IDLE, GEN, STREAM, DONE}.
- Sub-module rc_gen: LFSR, t counter and RC register.
  - Inputs: go, ir.
  - Outputs: rc[W-1:0], rc_done.
- The top level holds the FSM, the z counter and the output register.

Test Plan:
- L=6, ir=0, slices all zero, always ready -> RC = 64'h1; only slice z=0 has out bit0=1; out_last on z=63; done pulses once; GEN lasts 7 cycles.
- L=6, ir=1, slices all 25'h1FFFFFF -> RC = 64'h8082; bit0 cleared at z=1, 7, 15; all other bits stay 1.
- L=6, ir=23 -> RC = 64'h8000000080008008; GEN lasts 168 cycles; the out stream matches the reference model.
- L=3 (W=8), ir=0..17 in sequence -> RC equals the low 8 bits of each standard Keccak constant; 8 beats per round.
- Random out_ready, 30% stall, L=6, ir=5 -> no slice lost or duplicated; output stable during stalls; exactly 64 output beats.
- Edge cases:
  - round_in=24 with NR=24 -> err pulse, busy stays 0.
  - start while busy -> ignored.
  - rst=0 at z=30 -> outputs 0 immediately; the next start works normally.
